// File: rtl/pixel_color_scheduler.sv
// Round-robin arbiter that shares one color_map between Julia iteration cores
// and streams one frame of RGB pixels into the frame-buffer write port.
module pixel_color_scheduler #(
  parameter int unsigned NUM_CORES    = 4,
  parameter int unsigned ADDR_W       = 17,
  parameter int unsigned FRAME_PIXELS = 130560
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          frame_done,
  output logic [ADDR_W-1:0]             pixel_count,
  input  logic [NUM_CORES-1:0]          req_valid,
  input  logic [8*NUM_CORES-1:0]        req_value,
  input  logic [ADDR_W*NUM_CORES-1:0]   req_addr,
  output logic [NUM_CORES-1:0]          req_ready,
  output logic [7:0]                    cmap_value,
  input  logic [23:0]                   cmap_rgb,
  output logic                          fb_valid,
  input  logic                          fb_ready,
  output logic [ADDR_W-1:0]             fb_addr,
  output logic [23:0]                   fb_data
);

  localparam int unsigned       PTR_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [ADDR_W-1:0] FRAME_N = ADDR_W'(FRAME_PIXELS);
  localparam logic [PTR_W-1:0]  PTR_MAX = PTR_W'(NUM_CORES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              fb_valid_q, fb_valid_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [23:0]       fb_data_q, fb_data_d;
  logic              busy_q, done_q;

  logic [7:0]        val_a  [NUM_CORES];
  logic [ADDR_W-1:0] addr_a [NUM_CORES];
  logic              grant_found;
  logic [PTR_W-1:0]  grant_idx;
  logic              can_grant;
  logic              accept;

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      val_a[i]  = req_value[8*i +: 8];
      addr_a[i] = req_addr[ADDR_W*i +: ADDR_W];
    end
  end

  // First valid core at or after the pointer, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!grant_found &&
          req_valid[PTR_W'((32'(ptr_q) + 32'(k)) % NUM_CORES)]) begin
        grant_found = 1'b1;
        grant_idx   = PTR_W'((32'(ptr_q) + 32'(k)) % NUM_CORES);
      end
    end
  end

  assign can_grant = (state_q == S_RUN) && (count_q < FRAME_N) &&
                     (!fb_valid_q || fb_ready);
  assign accept    = can_grant && grant_found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  assign cmap_value = accept ? val_a[grant_idx] : 8'd0;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    fb_valid_d = fb_valid_q;
    fb_addr_d  = fb_addr_q;
    fb_data_d  = fb_data_q;

    if (fb_valid_q && fb_ready) fb_valid_d = 1'b0;
    // A fresh accept reloads the slot on the same edge it drains.
    if (accept) begin
      fb_valid_d = 1'b1;
      fb_addr_d  = addr_a[grant_idx];
      fb_data_d  = cmap_rgb;
      count_d    = count_q + ADDR_W'(1);
      ptr_d      = (grant_idx == PTR_MAX) ? '0 : grant_idx + PTR_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          count_d = '0;
        end
      end
      S_RUN:   if (accept && (count_d == FRAME_N)) state_d = S_FLUSH;
      S_FLUSH: if (!fb_valid_q || fb_ready) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      count_q    <= '0;
      fb_valid_q <= 1'b0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      fb_valid_q <= fb_valid_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
      busy_q     <= (state_d == S_RUN) || (state_d == S_FLUSH);
      done_q     <= (state_d == S_DONE);
    end
  end

  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign pixel_count = count_q;
  assign fb_valid    = fb_valid_q;
  assign fb_addr     = fb_addr_q;
  assign fb_data     = fb_data_q;

endmodule

// File: tb/tb_pixel_color_scheduler.sv
// Directed bench: three scheduler instances (frames of 4, 8 and 3 pixels)
// sharing core/frame-buffer stimulus, each started independently.
module tb_pixel_color_scheduler;

  localparam int unsigned NC = 4;
  localparam int unsigned AW = 17;

  logic              clk;
  logic              rst_n;
  logic [2:0]        start;
  logic [NC-1:0]     req_valid;
  logic [8*NC-1:0]   req_value;
  logic [AW*NC-1:0]  req_addr;
  logic              fb_ready;

  logic [2:0]        busy, frame_done, fb_valid;
  logic [AW-1:0]     pixel_count [3];
  logic [AW-1:0]     fb_addr     [3];
  logic [NC-1:0]     req_ready   [3];
  logic [7:0]        cmap_value  [3];
  logic [23:0]       cmap_rgb    [3];
  logic [23:0]       fb_data     [3];

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared color_map: known entries plus a reversible default.
  function automatic logic [23:0] cmap_model(input logic [7:0] v);
    case (v)
      8'd0:    return 24'h33AA00;
      8'd1:    return 24'h55AA00;
      8'd7:    return 24'hAA0000;
      8'd255:  return 24'h000000;
      default: return {v, 8'h5A, ~v};
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned FP = (g == 0) ? 4 : (g == 1) ? 8 : 3;
    assign cmap_rgb[g] = cmap_model(cmap_value[g]);
    pixel_color_scheduler #(
      .NUM_CORES(NC), .ADDR_W(AW), .FRAME_PIXELS(FP)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start[g]),
      .busy       (busy[g]),
      .frame_done (frame_done[g]),
      .pixel_count(pixel_count[g]),
      .req_valid  (req_valid),
      .req_value  (req_value),
      .req_addr   (req_addr),
      .req_ready  (req_ready[g]),
      .cmap_value (cmap_value[g]),
      .cmap_rgb   (cmap_rgb[g]),
      .fb_valid   (fb_valid[g]),
      .fb_ready   (fb_ready),
      .fb_addr    (fb_addr[g]),
      .fb_data    (fb_data[g])
    );
  end

  task automatic set_core(input int i, input logic [7:0] v, input logic [AW-1:0] a);
    req_value[8*i +: 8]   = v;
    req_addr[AW*i +: AW]  = a;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Leaves the caller at the negedge of the first RUN cycle.
  task automatic pulse_start(input int g);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    for (int i = 0; i < NC; i++) set_core(i, 8'(i + 5), AW'(i + 9));
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (busy[g] !== 1'b0 || frame_done[g] !== 1'b0 || fb_valid[g] !== 1'b0) begin
        failures++;
        $display("FAIL reset_flags[%0d] busy=%b done=%b fbv=%b exp=000", g, busy[g], frame_done[g], fb_valid[g]);
      end
      checks++;
      if (pixel_count[g] !== '0 || fb_addr[g] !== '0 || fb_data[g] !== 24'h0) begin
        failures++;
        $display("FAIL reset_regs[%0d] cnt=%h addr=%h data=%h exp=0", g, pixel_count[g], fb_addr[g], fb_data[g]);
      end
      checks++;
      if (req_ready[g] !== '0 || cmap_value[g] !== 8'd0) begin
        failures++;
        $display("FAIL reset_comb[%0d] ready=%b cmap=%h exp=0", g, req_ready[g], cmap_value[g]);
      end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (req_ready[g] !== '0 || busy[g] !== 1'b0) begin
          failures++;
          $display("FAIL idle_no_grant[%0d] ready=%b busy=%b exp=0", g, req_ready[g], busy[g]);
        end
      end
    end
  endtask

  task automatic test_single_core();
    logic [7:0]  vals [4];
    logic [23:0] exp_rgb [4];
    int idx, wr, last_wr, done_cnt, done_cyc;
    vals    = '{8'd0, 8'd1, 8'd7, 8'd255};
    exp_rgb = '{24'h33AA00, 24'h55AA00, 24'hAA0000, 24'h000000};
    do_reset();
    fb_ready  = 1'b1;
    req_valid = '0;
    pulse_start(0);
    idx = 0; wr = 0; last_wr = -1; done_cnt = 0; done_cyc = -1;
    for (int c = 0; c < 16; c++) begin
      req_valid = (idx < 4) ? 4'b0010 : 4'b0000;
      if (idx < 4) set_core(1, vals[idx], AW'(10 + idx));
      #1;
      checks++;
      if ((req_ready[0] & 4'b1101) !== 4'b0000) begin
        failures++;
        $display("FAIL single_ready_other c=%0d ready=%b exp=only_bit1", c, req_ready[0]);
      end
      if (fb_valid[0] && fb_ready) begin
        checks++;
        if (wr >= 4) begin
          failures++;
          $display("FAIL single_extra_write c=%0d addr=%h exp=no_write", c, fb_addr[0]);
        end else if (fb_addr[0] !== AW'(10 + wr) || fb_data[0] !== exp_rgb[wr]) begin
          failures++;
          $display("FAIL single_write%0d addr=%0d data=%h exp addr=%0d data=%h", wr, fb_addr[0], fb_data[0], 10 + wr, exp_rgb[wr]);
        end
        if (wr > 0) begin
          checks++;
          if (c != last_wr + 1) begin
            failures++;
            $display("FAIL single_rate c=%0d exp=%0d", c, last_wr + 1);
          end
        end
        last_wr = c;
        wr++;
      end
      if (frame_done[0]) begin
        done_cnt++;
        done_cyc = c;
      end
      if (req_ready[0][1]) idx++;
      @(negedge clk);
    end
    checks++;
    if (wr != 4 || done_cnt != 1 || done_cyc != last_wr + 1) begin
      failures++;
      $display("FAIL single_frame writes=%0d done=%0d done_cyc=%0d exp 4,1,%0d", wr, done_cnt, done_cyc, last_wr + 1);
    end
    checks++;
    if (pixel_count[0] !== AW'(4)) begin
      failures++;
      $display("FAIL single_count got=%0d exp=4", pixel_count[0]);
    end
  endtask

  task automatic test_fairness();
    int exp_order [2][8];
    int n, core;
    exp_order[0] = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp_order[1] = '{0, 1, 3, 0, 1, 3, 0, 1};
    do_reset();
    fb_ready  = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NC; i++) set_core(i, 8'(16 * i + 3), AW'(100 + i));
    for (int f = 0; f < 2; f++) begin
      pulse_start(1);
      n = 0;
      for (int c = 0; c < 30; c++) begin
        req_valid = (f == 1 && n >= 2) ? 4'b1011 : 4'b1111;
        #1;
        if (req_ready[1] !== '0) begin
          if (n < 8) begin
            core = exp_order[f][n];
            checks++;
            if (req_ready[1] !== (NC'(1) << core)) begin
              failures++;
              $display("FAIL fair_f%0d_g%0d ready=%b exp=%b", f, n, req_ready[1], NC'(1) << core);
            end
            checks++;
            if (cmap_value[1] !== 8'(16 * core + 3)) begin
              failures++;
              $display("FAIL fair_cmap_f%0d_g%0d got=%0d exp=%0d", f, n, cmap_value[1], 16 * core + 3);
            end
          end
          n++;
        end
        @(negedge clk);
      end
      checks++;
      if (n != 8) begin
        failures++;
        $display("FAIL fair_grants_f%0d got=%0d exp=8", f, n);
      end
    end
  endtask

  task automatic test_backpressure();
    int idx, wr, last_wr, stall;
    bit seen;
    do_reset();
    fb_ready  = 1'b1;
    req_valid = '0;
    pulse_start(0);
    idx = 0; wr = 0; last_wr = -1; stall = 0; seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      req_valid = (idx < 4) ? 4'b0001 : 4'b0000;
      if (idx < 4) set_core(0, 8'(20 + idx), AW'(50 + idx));
      if (fb_valid[0] && !seen) begin
        seen  = 1'b1;
        stall = 5;
      end
      fb_ready = (stall > 0) ? 1'b0 : 1'b1;
      #1;
      if (stall > 0) begin
        checks++;
        if (fb_addr[0] !== AW'(50) || fb_data[0] !== cmap_model(8'd20) || !fb_valid[0]) begin
          failures++;
          $display("FAIL bp_hold c=%0d addr=%0d data=%h v=%b exp 50 %h 1", c, fb_addr[0], fb_data[0], fb_valid[0], cmap_model(8'd20));
        end
        checks++;
        if (req_ready[0] !== '0 || pixel_count[0] !== AW'(1)) begin
          failures++;
          $display("FAIL bp_stall c=%0d ready=%b cnt=%0d exp 0 1", c, req_ready[0], pixel_count[0]);
        end
        stall--;
      end
      if (fb_valid[0] && fb_ready) begin
        checks++;
        if (fb_addr[0] !== AW'(50 + wr) || fb_data[0] !== cmap_model(8'(20 + wr))) begin
          failures++;
          $display("FAIL bp_write%0d addr=%0d data=%h exp %0d %h", wr, fb_addr[0], fb_data[0], 50 + wr, cmap_model(8'(20 + wr)));
        end
        if (wr > 0) begin
          checks++;
          if (c != last_wr + 1) begin
            failures++;
            $display("FAIL bp_rate c=%0d exp=%0d", c, last_wr + 1);
          end
        end
        last_wr = c;
        wr++;
      end
      if (req_ready[0][0]) idx++;
      @(negedge clk);
    end
    checks++;
    if (wr != 4 || pixel_count[0] !== AW'(4)) begin
      failures++;
      $display("FAIL bp_total writes=%0d cnt=%0d exp 4 4", wr, pixel_count[0]);
    end
  endtask

  task automatic test_frame_boundary();
    int idx, wr, w_cyc, done_cyc, done_cnt, stall;
    bit stalled;
    do_reset();
    fb_ready = 1'b1;
    pulse_start(2);
    idx = 0; wr = 0; w_cyc = -1; done_cyc = -1; done_cnt = 0; stall = 0; stalled = 1'b0;
    for (int c = 0; c < 14; c++) begin
      req_valid = 4'b1000;
      set_core(3, 8'(40 + idx), AW'(200 + idx));
      start[2] = (c == 1);
      if (pixel_count[2] == AW'(3) && fb_valid[2] && !stalled) begin
        stalled = 1'b1;
        stall   = 2;
      end
      fb_ready = (stall > 0) ? 1'b0 : 1'b1;
      #1;
      if (pixel_count[2] == AW'(3)) begin
        checks++;
        if (req_ready[2] !== '0) begin
          failures++;
          $display("FAIL fb_no_grant c=%0d ready=%b exp=0", c, req_ready[2]);
        end
      end
      if (stall > 0) begin
        checks++;
        if (busy[2] !== 1'b1 || frame_done[2] !== 1'b0) begin
          failures++;
          $display("FAIL fb_flush_busy c=%0d busy=%b done=%b exp 1 0", c, busy[2], frame_done[2]);
        end
        stall--;
      end
      if (fb_valid[2] && fb_ready) begin
        checks++;
        if (fb_addr[2] !== AW'(200 + wr) || fb_data[2] !== cmap_model(8'(40 + wr))) begin
          failures++;
          $display("FAIL fb_write%0d addr=%0d data=%h exp %0d %h", wr, fb_addr[2], fb_data[2], 200 + wr, cmap_model(8'(40 + wr)));
        end
        wr++;
        w_cyc = c;
      end
      if (frame_done[2]) begin
        done_cnt++;
        done_cyc = c;
        checks++;
        if (busy[2] !== 1'b0) begin
          failures++;
          $display("FAIL fb_busy_in_done got=%b exp=0", busy[2]);
        end
      end
      if (wr == 3 && c == w_cyc + 2) begin
        checks++;
        if (busy[2] !== 1'b0 || frame_done[2] !== 1'b0) begin
          failures++;
          $display("FAIL fb_idle_after busy=%b done=%b exp 0 0", busy[2], frame_done[2]);
        end
      end
      if (req_ready[2][3]) idx++;
      @(negedge clk);
    end
    start[2] = 1'b0;
    checks++;
    if (wr != 3 || done_cnt != 1 || done_cyc != w_cyc + 1) begin
      failures++;
      $display("FAIL fb_frame writes=%0d done=%0d done_cyc=%0d exp 3 1 %0d", wr, done_cnt, done_cyc, w_cyc + 1);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    do_reset();
    fb_ready  = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NC; i++) set_core(i, 8'(60 + i), AW'(300 + i));
    pulse_start(0);
    n = 0;
    while (pixel_count[0] !== AW'(2) && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 10) begin
      failures++;
      $display("FAIL mr_two_accepts cnt=%0d exp=2", pixel_count[0]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || frame_done[0] !== 1'b0 || fb_valid[0] !== 1'b0 ||
        pixel_count[0] !== '0 || fb_addr[0] !== '0 || fb_data[0] !== 24'h0) begin
      failures++;
      $display("FAIL mr_regs busy=%b done=%b v=%b cnt=%0d addr=%0d data=%h exp all 0",
               busy[0], frame_done[0], fb_valid[0], pixel_count[0], fb_addr[0], fb_data[0]);
    end
    checks++;
    if (req_ready[0] !== '0 || cmap_value[0] !== 8'd0) begin
      failures++;
      $display("FAIL mr_comb ready=%b cmap=%h exp 0 0", req_ready[0], cmap_value[0]);
    end
    rst_n = 1'b1;
    pulse_start(0);
    #1;
    checks++;
    if (pixel_count[0] !== '0 || busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL mr_restart cnt=%0d busy=%b exp 0 1", pixel_count[0], busy[0]);
    end
    checks++;
    if (req_ready[0] !== 4'b0001 || cmap_value[0] !== 8'd60) begin
      failures++;
      $display("FAIL mr_ptr ready=%b cmap=%0d exp 0001 60", req_ready[0], cmap_value[0]);
    end
    repeat (12) @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    start     = '0;
    fb_ready  = 1'b0;
    req_valid = '0;
    req_value = '0;
    req_addr  = '0;
    test_reset();
    test_single_core();
    test_fairness();
    test_backpressure();
    test_frame_boundary();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
